// File: rtl/ctrl_nested.sv
// ctrl_nested: pipeline control unit with IRQ pending/priority logic and a nested exception context stack.
// Define CTRL_VECTORED_EN to offset the exception target by the exception code.
module ctrl_nested #(
    parameter int IRQ_CH     = 8,
    parameter int NEST_DEPTH = 4,
    parameter int EXP_W      = 3,
    parameter int VEC_SHIFT  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [4:0]        creg_rd_addr,
    output logic [31:0]       creg_rd_data,
    output logic              exe_mode,
    input  logic [IRQ_CH-1:0] irq,
    output logic              int_detect,
    output logic [3:0]        int_id,
    input  logic [29:0]       id_pc,
    input  logic [29:0]       mem_pc,
    input  logic              mem_en,
    input  logic              mem_br_flag,
    input  logic [1:0]        mem_ctrl_op,
    input  logic [4:0]        mem_dst_addr,
    input  logic [EXP_W-1:0]  mem_exp_code,
    input  logic [31:0]       mem_out,
    input  logic              if_busy,
    input  logic              ld_hazard,
    input  logic              mem_busy,
    output logic              if_stall,
    output logic              id_stall,
    output logic              ex_stall,
    output logic              mem_stall,
    output logic              if_flush,
    output logic              id_flush,
    output logic              ex_flush,
    output logic              mem_flush,
    output logic [29:0]       new_pc,
    output logic              nest_overflow
);
    localparam int IW = NEST_DEPTH > 1 ? $clog2(NEST_DEPTH) : 1;
`ifdef CTRL_VECTORED_EN
    localparam bit VEC = 1'b1;
`else
    localparam bit VEC = 1'b0;
`endif
    logic              mode_q, ien_q, br_flag, ovf_q;
    logic [IRQ_CH-1:0] mask_q, trig_q, edge_q, irq_q, pend, act, clr;
    logic [29:0]       exp_vector, pre_pc, exc_tgt, top_epc;
    logic [3:0]        depth;
    logic [IW-1:0]     top, push;
    logic              stk_mode [NEST_DEPTH];
    logic              stk_ien  [NEST_DEPTH];
    logic              stk_dly  [NEST_DEPTH];
    logic [29:0]       stk_epc  [NEST_DEPTH];
    logic [EXP_W-1:0]  stk_code [NEST_DEPTH];
    logic              stall, flush, commit, exc, exrt, wrcr, do_exc, do_exrt, do_wr, has, full;

    assign stall   = if_busy | mem_busy;
    assign exc     = |mem_exp_code;
    assign exrt    = mem_ctrl_op == 2'd2;
    assign wrcr    = mem_ctrl_op == 2'd1;
    assign flush   = mem_en & (exc | exrt | wrcr);
    assign commit  = mem_en & ~stall;
    assign do_exc  = commit & exc;
    assign do_exrt = commit & ~exc & exrt;
    assign do_wr   = commit & ~exc & ~exrt & wrcr;
    assign has     = |depth;
    assign full    = depth == 4'(NEST_DEPTH);
    assign top     = IW'(depth - 4'd1);
    assign push    = IW'(depth);

    assign if_stall  = stall | ld_hazard;
    assign id_stall  = stall;
    assign ex_stall  = stall;
    assign mem_stall = stall;
    assign if_flush  = flush;
    assign id_flush  = flush | ld_hazard;
    assign ex_flush  = flush;
    assign mem_flush = flush;

    // Level channels mirror the delayed request; edge channels hold a sticky bit.
    assign pend    = (trig_q & edge_q) | (~trig_q & irq_q);
    assign act     = pend & ~mask_q;
    assign clr     = (do_wr && mem_dst_addr == 5'd10) ? mem_out[IRQ_CH-1:0] : '0;
    assign exc_tgt = exp_vector + (VEC ? (30'(mem_exp_code) << VEC_SHIFT) : 30'd0);
    assign top_epc = has ? stk_epc[top] : '0;
    assign new_pc  = !mem_en ? '0 : exc ? exc_tgt : exrt ? top_epc : wrcr ? mem_pc : '0;

    assign exe_mode      = mode_q & ~reset;
    assign nest_overflow = ovf_q & ~reset;
    assign int_detect    = ien_q & |act & ~reset;

    always_comb begin
        int_id = '0;
        for (int i = IRQ_CH - 1; i >= 0; i--)
            if (act[i] && !reset) int_id = 4'(i);
    end

    always_comb begin
        case (creg_rd_addr)
            5'd0:    creg_rd_data = 32'({ien_q, mode_q});
            5'd1:    creg_rd_data = has ? 32'({stk_ien[top], stk_mode[top]}) : '0;
            5'd2:    creg_rd_data = {id_pc, 2'b0};
            5'd3:    creg_rd_data = {top_epc, 2'b0};
            5'd4:    creg_rd_data = 32'(exp_vector);
            5'd5:    creg_rd_data = has ? 32'({stk_dly[top], stk_code[top]}) : '0;
            5'd6:    creg_rd_data = 32'(mask_q);
            5'd7:    creg_rd_data = 32'(pend);
            5'd8:    creg_rd_data = 32'(trig_q);
            5'd9:    creg_rd_data = {23'b0, ovf_q, 4'b0, depth};
            default: creg_rd_data = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mode_q     <= 1'b0;
            ien_q      <= 1'b0;
            mask_q     <= '1;
            trig_q     <= '0;
            edge_q     <= '0;
            irq_q      <= '0;
            exp_vector <= '0;
            depth      <= '0;
            ovf_q      <= 1'b0;
            pre_pc     <= '0;
            br_flag    <= 1'b0;
        end else begin
            irq_q  <= irq;
            edge_q <= trig_q & ((edge_q & ~clr) | (irq & ~irq_q));
            if (commit) begin
                pre_pc  <= mem_pc;
                br_flag <= mem_br_flag;
            end
            if (do_exc) begin
                mode_q <= 1'b0;
                ien_q  <= 1'b0;
                if (full) ovf_q <= 1'b1;
                else depth <= depth + 4'd1;
            end
            if (do_exrt && has) begin
                mode_q <= stk_mode[top];
                ien_q  <= stk_ien[top];
                depth  <= depth - 4'd1;
            end
            if (do_wr) begin
                case (mem_dst_addr)
                    5'd0:    {ien_q, mode_q} <= mem_out[1:0];
                    5'd4:    exp_vector <= mem_out[29:0];
                    5'd6:    mask_q <= mem_out[IRQ_CH-1:0];
                    5'd8:    trig_q <= mem_out[IRQ_CH-1:0];
                    5'd9:    ovf_q <= 1'b0;
                    default: ;
                endcase
            end
        end
    end

    // Stack storage needs no reset: depth alone decides what is visible.
    always_ff @(posedge clk) begin
        if (do_exc && !full) begin
            stk_mode[push] <= mode_q;
            stk_ien[push]  <= ien_q;
            stk_epc[push]  <= pre_pc;
            stk_code[push] <= mem_exp_code;
            stk_dly[push]  <= br_flag;
        end
        if (do_wr && has) begin
            case (mem_dst_addr)
                5'd1:    {stk_ien[top], stk_mode[top]} <= mem_out[1:0];
                5'd3:    stk_epc[top] <= mem_out[31:2];
                5'd5:    {stk_dly[top], stk_code[top]} <= mem_out[EXP_W:0];
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_ctrl_nested.sv
// tb_ctrl_nested: directed scenarios plus randomized traffic against a queue-based reference model.
module tb_ctrl_nested;
    logic        clk = 1'b0, reset = 1'b1;
    logic [4:0]  creg_rd_addr = '0;
    logic [31:0] creg_rd_data;
    logic        exe_mode, int_detect, nest_overflow;
    logic [7:0]  irq = '0;
    logic [3:0]  int_id;
    logic [29:0] id_pc = '0, mem_pc = '0, new_pc;
    logic        mem_en = 0, mem_br_flag = 0, if_busy = 0, ld_hazard = 0, mem_busy = 0;
    logic [1:0]  mem_ctrl_op = '0;
    logic [4:0]  mem_dst_addr = '0;
    logic [2:0]  mem_exp_code = '0;
    logic [31:0] mem_out = '0;
    logic        if_stall, id_stall, ex_stall, mem_stall, if_flush, id_flush, ex_flush, mem_flush;
    int total = 0, bad = 0;

    always #20 clk = ~clk;

    ctrl_nested dut (
        .clk(clk), .reset(reset), .creg_rd_addr(creg_rd_addr), .creg_rd_data(creg_rd_data),
        .exe_mode(exe_mode), .irq(irq), .int_detect(int_detect), .int_id(int_id),
        .id_pc(id_pc), .mem_pc(mem_pc), .mem_en(mem_en), .mem_br_flag(mem_br_flag),
        .mem_ctrl_op(mem_ctrl_op), .mem_dst_addr(mem_dst_addr), .mem_exp_code(mem_exp_code),
        .mem_out(mem_out), .if_busy(if_busy), .ld_hazard(ld_hazard), .mem_busy(mem_busy),
        .if_stall(if_stall), .id_stall(id_stall), .ex_stall(ex_stall), .mem_stall(mem_stall),
        .if_flush(if_flush), .id_flush(id_flush), .ex_flush(ex_flush), .mem_flush(mem_flush),
        .new_pc(new_pc), .nest_overflow(nest_overflow)
    );

    typedef struct { bit mode; bit ien; logic [29:0] epc; logic [2:0] code; bit dly; } ctx_t;
    ctx_t        stk[$];
    bit          m_mode, m_ien, m_br, m_ovf;
    logic [7:0]  m_mask, m_trig, m_edge, m_irq_q;
    logic [29:0] m_vec, m_pre;

    function automatic logic [7:0] m_pend();
        logic [7:0] p;
        for (int i = 0; i < 8; i++) p[i] = m_trig[i] ? m_edge[i] : m_irq_q[i];
        return p;
    endfunction

    function automatic logic [3:0] m_id();
        logic [7:0] a;
        a = m_pend() & ~m_mask;
        if (reset) return 4'd0;
        for (int i = 0; i < 8; i++) if (a[i]) return 4'(i);
        return 4'd0;
    endfunction

    function automatic logic m_detect();
        return !reset && m_ien && ((m_pend() & ~m_mask) != 8'h0);
    endfunction

    function automatic logic [29:0] m_new_pc();
        if (!mem_en) return 30'd0;
`ifdef CTRL_VECTORED_EN
        if (mem_exp_code != 0) return m_vec + 30'(mem_exp_code * 16);
`else
        if (mem_exp_code != 0) return m_vec;
`endif
        if (mem_ctrl_op == 2'd2) return stk.size() > 0 ? stk[$].epc : 30'd0;
        if (mem_ctrl_op == 2'd1) return mem_pc;
        return 30'd0;
    endfunction

    function automatic logic [7:0] m_sf();
        logic s, f;
        s = if_busy | mem_busy;
        f = mem_en && (mem_exp_code != 0 || mem_ctrl_op == 2'd1 || mem_ctrl_op == 2'd2);
        return {s | ld_hazard, s, s, s, f, f | ld_hazard, f, f};
    endfunction

    function automatic logic [31:0] m_rd(input logic [4:0] a);
        bit h;
        h = stk.size() > 0;
        case (a)
            5'd0: return 32'({m_ien, m_mode});
            5'd1: return h ? 32'({stk[$].ien, stk[$].mode}) : 32'd0;
            5'd2: return {id_pc, 2'b0};
            5'd3: return h ? {stk[$].epc, 2'b0} : 32'd0;
            5'd4: return 32'(m_vec);
            5'd5: return h ? 32'(stk[$].dly) * 8 + 32'(stk[$].code) : 32'd0;
            5'd6: return 32'(m_mask);
            5'd7: return 32'(m_pend());
            5'd8: return 32'(m_trig);
            5'd9: return 32'(m_ovf) * 256 + 32'(stk.size());
            default: return 32'd0;
        endcase
    endfunction

    function automatic void model_step();
        bit commit, exc;
        logic [7:0] clr;
        ctx_t c;
        if (reset) begin
            m_mode = 0; m_ien = 0; m_br = 0; m_ovf = 0; m_mask = 8'hff; m_trig = 0;
            m_edge = 0; m_irq_q = 0; m_vec = 0; m_pre = 0; stk.delete();
            return;
        end
        commit = mem_en && !(if_busy || mem_busy);
        exc = mem_exp_code != 0;
        clr = (commit && !exc && mem_ctrl_op == 2'd1 && mem_dst_addr == 5'd10) ? mem_out[7:0] : 8'h0;
        for (int i = 0; i < 8; i++)
            if (!m_trig[i]) m_edge[i] = 0;
            else if (irq[i] && !m_irq_q[i]) m_edge[i] = 1;
            else if (clr[i]) m_edge[i] = 0;
        m_irq_q = irq;
        if (!commit) return;
        if (exc) begin
            if (stk.size() < 4) begin
                c.mode = m_mode; c.ien = m_ien; c.epc = m_pre; c.code = mem_exp_code; c.dly = m_br;
                stk.push_back(c);
            end else m_ovf = 1;
            m_mode = 0; m_ien = 0;
        end else if (mem_ctrl_op == 2'd2) begin
            if (stk.size() > 0) begin
                c = stk.pop_back();
                m_mode = c.mode; m_ien = c.ien;
            end
        end else if (mem_ctrl_op == 2'd1) begin
            if (stk.size() > 0) c = stk[$];
            case (mem_dst_addr)
                5'd0: begin m_ien = mem_out[1]; m_mode = mem_out[0]; end
                5'd1: begin c.ien = mem_out[1]; c.mode = mem_out[0]; end
                5'd3: c.epc = mem_out[31:2];
                5'd4: m_vec = mem_out[29:0];
                5'd5: begin c.dly = mem_out[3]; c.code = mem_out[2:0]; end
                5'd6: m_mask = mem_out[7:0];
                5'd8: m_trig = mem_out[7:0];
                5'd9: m_ovf = 0;
                default: ;
            endcase
            if (stk.size() > 0) stk[stk.size() - 1] = c;
        end
        m_pre = mem_pc;
        m_br = mem_br_flag;
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic rd(input logic [4:0] a, output logic [31:0] d);
        creg_rd_addr = a;
        #1 d = creg_rd_data;
    endtask

    task automatic commit_op(input logic [1:0] op, input logic [4:0] dst, input logic [31:0] d,
                             input logic [2:0] code, input logic [29:0] pc);
        mem_en = 1; mem_ctrl_op = op; mem_dst_addr = dst; mem_out = d; mem_exp_code = code; mem_pc = pc;
        tick();
        mem_en = 0; mem_ctrl_op = 0; mem_exp_code = 0;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        reset = 1; tick(); tick(); reset = 0;
        rd(5'd6, d);
        total++; if (d !== 32'hff) begin bad++; $display("FAIL reset_mask got=%h want=%h", d, 32'hff); end
        rd(5'd0, d);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL reset_status got=%h want=0", d); end
        rd(5'd9, d);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL reset_nest got=%h want=0", d); end
        total++; if ({exe_mode, int_detect, nest_overflow, new_pc} !== '0) begin
            bad++; $display("FAIL reset_outputs got=%b%b%b %h want=0", exe_mode, int_detect, nest_overflow, new_pc); end
    endtask

    task automatic test_irq();
        logic [31:0] d;
        commit_op(2'd1, 5'd6, 32'h0, 3'd0, 30'h10);
        commit_op(2'd1, 5'd0, 32'h2, 3'd0, 30'h11);
        commit_op(2'd1, 5'd8, 32'h8, 3'd0, 30'h12);
        irq = 8'h08; tick(); irq = 8'h00; tick();
        #1;
        total++; if ({int_detect, int_id} !== 5'h13) begin
            bad++; $display("FAIL irq_edge got=%b/%0d want=1/3", int_detect, int_id); end
        commit_op(2'd1, 5'd10, 32'h8, 3'd0, 30'h13);
        rd(5'd7, d);
        total++; if (d !== 32'h0 || int_detect !== 1'b0) begin
            bad++; $display("FAIL irq_w1c got=%h/%b want=0/0", d, int_detect); end
        irq = 8'h02; tick();
        #1;
        total++; if ({int_detect, int_id} !== 5'h11) begin
            bad++; $display("FAIL irq_level got=%b/%0d want=1/1", int_detect, int_id); end
        commit_op(2'd1, 5'd10, 32'h2, 3'd0, 30'h14);
        rd(5'd7, d);
        total++; if (d !== 32'h2) begin bad++; $display("FAIL irq_level_w1c got=%h want=2", d); end
        irq = 8'h00; tick();
        #1;
        total++; if (int_detect !== 1'b0) begin bad++; $display("FAIL irq_level_drop got=%b want=0", int_detect); end
    endtask

    task automatic test_exception();
        logic [31:0] d;
        logic [29:0] want;
`ifdef CTRL_VECTORED_EN
        want = 30'h120;
`else
        want = 30'h100;
`endif
        commit_op(2'd1, 5'd0, 32'h3, 3'd0, 30'h3c);
        commit_op(2'd1, 5'd4, 32'h100, 3'd0, 30'h40);
        mem_en = 1; mem_ctrl_op = 0; mem_exp_code = 3'd2; mem_pc = 30'h44;
        #1;
        total++; if ({if_flush, id_flush, ex_flush, mem_flush} !== 4'hf || new_pc !== want) begin
            bad++; $display("FAIL exc_flush got=%b/%h want=1111/%h", {if_flush, id_flush, ex_flush, mem_flush}, new_pc, want); end
        tick(); mem_en = 0; mem_exp_code = 0;
        rd(5'd0, d);
        total++; if (exe_mode !== 1'b0 || d !== 32'h0) begin
            bad++; $display("FAIL exc_mode got=%b/%h want=0/0", exe_mode, d); end
        rd(5'd9, d);
        total++; if (d !== 32'h1) begin bad++; $display("FAIL exc_nest got=%h want=1", d); end
        rd(5'd3, d);
        total++; if (d !== 32'h100) begin bad++; $display("FAIL exc_epc got=%h want=100", d); end
        rd(5'd5, d);
        total++; if (d !== 32'h2) begin bad++; $display("FAIL exc_cause got=%h want=2", d); end
        rd(5'd1, d);
        total++; if (d !== 32'h3) begin bad++; $display("FAIL exc_prestatus got=%h want=3", d); end
        mem_en = 1; mem_ctrl_op = 2'd2; mem_pc = 30'h50;
        #1;
        total++; if (new_pc !== 30'h40) begin bad++; $display("FAIL exrt_pc got=%h want=40", new_pc); end
        tick(); mem_en = 0; mem_ctrl_op = 0;
        rd(5'd9, d);
        total++; if (exe_mode !== 1'b1 || d !== 32'h0) begin
            bad++; $display("FAIL exrt_restore got=%b/%h want=1/0", exe_mode, d); end
    endtask

    task automatic test_nest();
        logic [31:0] d;
        logic [29:0] epcs[$];
        commit_op(2'd1, 5'd0, 32'h1, 3'd0, 30'h200);
        epcs = '{30'h200, 30'h300, 30'h301, 30'h302};
        for (int k = 0; k < 5; k++) commit_op(2'd0, 5'd0, 32'h0, 3'(k + 1), 30'h300 + 30'(k));
        rd(5'd9, d);
        total++; if (d !== 32'h104 || nest_overflow !== 1'b1) begin
            bad++; $display("FAIL nest_full got=%h/%b want=104/1", d, nest_overflow); end
        for (int k = 0; k < 4; k++) begin
            logic [29:0] w;
            w = epcs.pop_back();
            mem_en = 1; mem_ctrl_op = 2'd2; mem_pc = 30'h400 + 30'(k);
            #1;
            total++; if (new_pc !== w) begin bad++; $display("FAIL nest_lifo%0d got=%h want=%h", k, new_pc, w); end
            tick(); mem_en = 0; mem_ctrl_op = 0;
        end
        rd(5'd9, d);
        total++; if (d !== 32'h100 || exe_mode !== 1'b1) begin
            bad++; $display("FAIL nest_empty got=%h/%b want=100/1", d, exe_mode); end
        mem_en = 1; mem_ctrl_op = 2'd2;
        #1;
        total++; if (new_pc !== 30'h0 || mem_flush !== 1'b1) begin
            bad++; $display("FAIL nest_extra_exrt got=%h/%b want=0/1", new_pc, mem_flush); end
        tick(); mem_en = 0; mem_ctrl_op = 0;
        total++; if (exe_mode !== 1'b1) begin bad++; $display("FAIL nest_extra_mode got=%b want=1", exe_mode); end
        commit_op(2'd1, 5'd9, 32'h0, 3'd0, 30'h410);
        total++; if (nest_overflow !== 1'b0) begin bad++; $display("FAIL nest_ovf_clear got=%b want=0", nest_overflow); end
    endtask

    task automatic test_stall();
        logic [31:0] d;
        mem_busy = 1; mem_en = 1; mem_exp_code = 3'd3; mem_pc = 30'h500;
        #1;
        total++; if ({if_stall, id_stall, ex_stall, mem_stall} !== 4'hf) begin
            bad++; $display("FAIL stall_all got=%b want=1111", {if_stall, id_stall, ex_stall, mem_stall}); end
        tick(); tick();
        rd(5'd9, d);
        total++; if (d !== 32'h0 || exe_mode !== 1'b1) begin
            bad++; $display("FAIL stall_hold got=%h/%b want=0/1", d, exe_mode); end
        mem_busy = 0; tick(); mem_en = 0; mem_exp_code = 0; tick();
        rd(5'd9, d);
        total++; if (d !== 32'h1 || exe_mode !== 1'b0) begin
            bad++; $display("FAIL stall_once got=%h/%b want=1/0", d, exe_mode); end
        commit_op(2'd2, 5'd0, 32'h0, 3'd0, 30'h510);
    endtask

    task automatic test_ld_hazard();
        ld_hazard = 1;
        #1;
        total++; if ({if_stall, id_stall, ex_stall, mem_stall, if_flush, id_flush, ex_flush, mem_flush} !== 8'b1000_0100) begin
            bad++; $display("FAIL ld_hazard got=%b want=10000100",
                {if_stall, id_stall, ex_stall, mem_stall, if_flush, id_flush, ex_flush, mem_flush}); end
        ld_hazard = 0;
    endtask

    task automatic test_reset_nest();
        logic [31:0] d;
        commit_op(2'd1, 5'd0, 32'h1, 3'd0, 30'h600);
        commit_op(2'd1, 5'd6, 32'h0, 3'd0, 30'h601);
        for (int k = 0; k < 3; k++) commit_op(2'd0, 5'd0, 32'h0, 3'd1, 30'h610 + 30'(k));
        rd(5'd9, d);
        total++; if (d !== 32'h3) begin bad++; $display("FAIL rn_depth got=%h want=3", d); end
        reset = 1; tick(); reset = 0;
        rd(5'd9, d);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL rn_nest got=%h want=0", d); end
        rd(5'd6, d);
        total++; if (d !== 32'hff || exe_mode !== 1'b0) begin
            bad++; $display("FAIL rn_state got=%h/%b want=ff/0", d, exe_mode); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 800; n++) begin
            reset = $urandom_range(0, 63) == 0;
            if ($urandom_range(0, 3) == 0) irq = 8'($urandom);
            mem_en = 1'($urandom);
            mem_ctrl_op = 2'($urandom);
            mem_dst_addr = 5'($urandom_range(0, 11));
            mem_out = $urandom;
            mem_exp_code = $urandom_range(0, 5) == 0 ? 3'($urandom_range(1, 7)) : 3'd0;
            mem_pc = 30'($urandom);
            mem_br_flag = 1'($urandom);
            if_busy = $urandom_range(0, 7) == 0;
            mem_busy = $urandom_range(0, 7) == 0;
            ld_hazard = $urandom_range(0, 7) == 0;
            id_pc = 30'($urandom);
            creg_rd_addr = 5'($urandom_range(0, 11));
            #1;
            total++; if (creg_rd_data !== m_rd(creg_rd_addr)) begin
                bad++; $display("FAIL rnd_rd%0d addr=%0d got=%h want=%h", n, creg_rd_addr, creg_rd_data, m_rd(creg_rd_addr)); end
            total++; if (new_pc !== m_new_pc()) begin
                bad++; $display("FAIL rnd_new_pc%0d got=%h want=%h", n, new_pc, m_new_pc()); end
            total++; if ({int_detect, int_id} !== {m_detect(), m_id()}) begin
                bad++; $display("FAIL rnd_int%0d got=%b/%0d want=%b/%0d", n, int_detect, int_id, m_detect(), m_id()); end
            total++; if ({exe_mode, nest_overflow} !== {m_mode & !reset, m_ovf & !reset}) begin
                bad++; $display("FAIL rnd_mode%0d got=%b%b want=%b%b", n, exe_mode, nest_overflow, m_mode & !reset, m_ovf & !reset); end
            total++; if ({if_stall, id_stall, ex_stall, mem_stall, if_flush, id_flush, ex_flush, mem_flush} !== m_sf()) begin
                bad++; $display("FAIL rnd_sf%0d got=%b want=%b", n,
                    {if_stall, id_stall, ex_stall, mem_stall, if_flush, id_flush, ex_flush, mem_flush}, m_sf()); end
            tick();
        end
        reset = 0; mem_en = 0; if_busy = 0; mem_busy = 0; ld_hazard = 0;
    endtask

    initial begin
        test_reset();
        test_irq();
        test_exception();
        test_nest();
        test_stall();
        test_ld_hazard();
        test_reset_nest();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
